// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  localparam int DMEM_BE_W  = 4;
  localparam int DMEM_CNT_W = 4;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response bus between an initiator and the data-memory responder
interface dmem_if #(
  parameter int BIT_WIDTH = 32
);
  import dmem_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [31:0]          req_addr;
  logic [BIT_WIDTH-1:0] req_wdata;
  logic [DMEM_BE_W-1:0] req_be;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [BIT_WIDTH-1:0] rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with byte-enabled synchronous write and asynchronous read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int ENTRY_COUNT = 32,
  parameter int IDX_W       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     idx,
  input  logic [BIT_WIDTH-1:0] wdata,
  input  logic [DMEM_BE_W-1:0] be,
  output logic [BIT_WIDTH-1:0] rdata
);

  logic [BIT_WIDTH-1:0] mem [ENTRY_COUNT];
  logic [BIT_WIDTH-1:0] mask;

  // Expand byte enables to a bit mask; bits beyond the enabled lanes are never written.
  always_comb begin
    mask = '0;
    for (int b = 0; b < BIT_WIDTH; b++) begin
      if (b / 8 < DMEM_BE_W) mask[b] = be[b/8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_COUNT; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= (mem[idx] & ~mask) | (wdata & mask);
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder in front of dmem_array
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int BIT_WIDTH   = 32,
  parameter int ENTRY_COUNT = 32,
  parameter int LATENCY     = 2
) (
  input  logic clk,
  input  logic rst,
  dmem_if.slave bus,
  output logic busy
);

  localparam int                    IDX_W      = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
  localparam logic [31:0]           ADDR_LIMIT = 32'(4 * ENTRY_COUNT);
  localparam logic [DMEM_CNT_W-1:0] CNT_INIT   = DMEM_CNT_W'(LATENCY - 1);
  localparam logic [DMEM_CNT_W-1:0] CNT_LAST   = 1;

  dmem_state_t          state;
  logic [DMEM_CNT_W-1:0] cnt;

  logic                 we_q;
  logic [31:0]          addr_q;
  logic [BIT_WIDTH-1:0] wdata_q;
  logic [DMEM_BE_W-1:0] be_q;

  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic                 busy_q;
  logic [BIT_WIDTH-1:0] rsp_rdata_q;

  logic                 accept;
  logic                 enter_resp;
  logic                 cur_we;
  logic [31:0]          cur_addr;
  logic [BIT_WIDTH-1:0] cur_wdata;
  logic [DMEM_BE_W-1:0] cur_be;
  logic                 cur_err;
  logic                 wr_en;
  logic [BIT_WIDTH-1:0] rd_word;
  logic [BIT_WIDTH-1:0] rsp_next;

  assign accept = (state == IDLE) && bus.req_valid;

  // With LATENCY=1 the access happens on the accept edge itself, before the latches hold the request.
  assign cur_we    = (state == IDLE) ? bus.req_we    : we_q;
  assign cur_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
  assign cur_be    = (state == IDLE) ? bus.req_be    : be_q;

  assign enter_resp = (accept && LATENCY == 1) || (state == WAIT && cnt == CNT_LAST);
  assign cur_err    = (cur_addr[1:0] != 2'b00) || (cur_addr >= ADDR_LIMIT);
  assign wr_en      = enter_resp && cur_we && !cur_err;
  assign rsp_next   = (cur_we || cur_err) ? '0 : rd_word;

  dmem_array #(
    .BIT_WIDTH  (BIT_WIDTH),
    .ENTRY_COUNT(ENTRY_COUNT),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en),
    .idx  (cur_addr[IDX_W+1:2]),
    .wdata(cur_wdata),
    .be   (cur_be),
    .rdata(rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q        <= bus.req_we;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            be_q        <= bus.req_be;
            cnt         <= CNT_INIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (LATENCY > 1) begin
              state <= WAIT;
            end else begin
              state       <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_next;
              rsp_err_q   <= cur_err;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_next;
            rsp_err_q   <= cur_err;
          end
        end
        RESP: begin
          // Returning to IDLE here means the next accept is at least one cycle after the handshake.
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at LATENCY 2 and 1
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy0, busy1;
  int   passed = 0;
  int   total  = 0;

  logic [31:0] m0 [32];
  logic [31:0] m1 [32];

  always #5 clk = ~clk;

  dmem_if #(.BIT_WIDTH(32)) b0 ();
  dmem_if #(.BIT_WIDTH(32)) b1 ();

  dmem_responder #(.BIT_WIDTH(32), .ENTRY_COUNT(32), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .busy(busy0)
  );

  dmem_responder #(.BIT_WIDTH(32), .ENTRY_COUNT(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b1.req_ready : b0.req_ready;
  endfunction
  function automatic logic rv(input bit sel);
    return sel ? b1.rsp_valid : b0.rsp_valid;
  endfunction
  function automatic logic re(input bit sel);
    return sel ? b1.rsp_err : b0.rsp_err;
  endfunction
  function automatic logic bsy(input bit sel);
    return sel ? busy1 : busy0;
  endfunction
  function automatic logic [31:0] rd(input bit sel);
    return sel ? b1.rsp_rdata : b0.rsp_rdata;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (sel) begin
      b1.req_valid = v; b1.req_we = we; b1.req_addr = a; b1.req_wdata = d; b1.req_be = be;
    end else begin
      b0.req_valid = v; b0.req_we = we; b0.req_addr = a; b0.req_wdata = d; b0.req_be = be;
    end
  endtask

  task automatic set_rr(input bit sel, input logic v);
    if (sel) b1.rsp_ready = v;
    else     b0.rsp_ready = v;
  endtask

  // Reference: word-addressed byte memory; misaligned or beyond 32 words is an error.
  task automatic model_txn(input bit sel, input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, output logic [31:0] rdat, output logic err);
    logic [31:0] w;
    int          i;
    err  = (a % 4 != 0) || (a >= 32'd128);
    rdat = 32'd0;
    if (!err) begin
      i = int'(a / 4);
      w = sel ? m1[i] : m0[i];
      if (we) begin
        for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = d[8*k +: 8];
        if (sel) m1[i] = w;
        else     m0[i] = w;
      end else begin
        rdat = w;
      end
    end
  endtask

  task automatic txn(input bit sel, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input int hold);
    logic [31:0] er, held_d;
    logic        ee, held_e;
    int          n, lat;
    lat = sel ? 1 : 2;
    @(negedge clk);
    n = 0;
    while (!rdy(sel) && n < 20) begin @(negedge clk); n++; end
    check("req_ready_idle", 32'(rdy(sel)), 32'd1);
    set_rr(sel, hold == 0);
    drive(sel, 1'b1, we, a, d, be);
    @(posedge clk); #1;
    drive(sel, 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
    model_txn(sel, we, a, d, be, er, ee);
    check("busy_after_accept", 32'(bsy(sel)), 32'd1);
    n = 1;
    while (!rv(sel) && n < 20) begin @(posedge clk); #1; n++; end
    check("latency", 32'(n), 32'(lat));
    held_d = rd(sel);
    held_e = re(sel);
    for (int c = 0; c < hold; c++) begin
      drive(sel, 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom));
      @(posedge clk); #1;
      check("hold_valid", 32'(rv(sel)), 32'd1);
      check("hold_rdata", rd(sel), held_d);
      check("hold_err", 32'(re(sel)), 32'(held_e));
      check("hold_req_ready", 32'(rdy(sel)), 32'd0);
    end
    set_rr(sel, 1'b1);
    check("rsp_rdata", rd(sel), er);
    check("rsp_err", 32'(re(sel)), 32'(ee));
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check("rsp_valid_drop", 32'(rv(sel)), 32'd0);
    check("rdata_retained", rd(sel), er);
    check("err_retained", 32'(re(sel)), 32'(ee));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int acc[$];
    int cyc;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_rr(0, 1'b1);
    set_rr(1, 1'b1);
    for (int i = 0; i < 32; i++) begin m0[i] = 32'd0; m1[i] = 32'd0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(b0.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(b0.rsp_valid), 32'd0);
    check("rst_rsp_rdata", b0.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(b0.rsp_err), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_req_ready_l1", 32'(b1.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    txn(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0);
    txn(0, 1'b0, 32'h08, 32'd0, 4'd0, 0);
    check("store_load_word", b0.rsp_rdata, 32'hDEADBEEF);
    check("store_load_err", 32'(b0.rsp_err), 32'd0);

    txn(0, 1'b1, 32'h08, 32'h11223344, 4'b0101, 0);
    txn(0, 1'b0, 32'h08, 32'd0, 4'd0, 0);
    check("partial_store", b0.rsp_rdata, 32'hDE22BE44);

    txn(0, 1'b0, 32'h06, 32'd0, 4'd0, 0);
    check("misaligned_err", 32'(b0.rsp_err), 32'd1);
    check("misaligned_rdata", b0.rsp_rdata, 32'd0);
    txn(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, 0);
    check("range_err", 32'(b0.rsp_err), 32'd1);
    check("range_rdata", b0.rsp_rdata, 32'd0);

    txn(0, 1'b1, 32'h0C, 32'h12345678, 4'h0, 1);
    check("be_zero_no_err", 32'(b0.rsp_err), 32'd0);

    txn(0, 1'b0, 32'h08, 32'd0, 4'd0, 5);

    for (int t = 0; t < 40; t++) begin
      int          r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, 31)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
      else             a = 32'd128 + (32'($urandom_range(0, 1023)) << 2);
      txn(0, 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 32; i++) txn(0, 1'b0, 32'(i) << 2, 32'd0, 4'd0, 0);

    txn(1, 1'b1, 32'h10, $urandom, 4'hF, 0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h10, 32'd0, 4'd0);
    set_rr(1, 1'b1);
    cyc = 0;
    repeat (12) begin
      if (b1.req_ready) acc.push_back(cyc);
      @(posedge clk); #1;
      if (b1.rsp_valid) check("b2b_rdata", b1.rsp_rdata, m1[4]);
      @(negedge clk);
      cyc++;
    end
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check("b2b_accepts", 32'(acc.size()), 32'd6);
    for (int i = 1; i < acc.size(); i++) check("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd2);
    repeat (3) @(posedge clk);

    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h04, 32'hCAFEF00D, 4'hF);
    set_rr(0, 1'b1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    check("abort_busy_pre", 32'(busy0), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_req_ready", 32'(b0.req_ready), 32'd1);
    check("abort_rsp_valid", 32'(b0.rsp_valid), 32'd0);
    check("abort_rsp_rdata", b0.rsp_rdata, 32'd0);
    check("abort_rsp_err", 32'(b0.rsp_err), 32'd0);
    check("abort_busy", 32'(busy0), 32'd0);
    for (int i = 0; i < 32; i++) begin m0[i] = 32'd0; m1[i] = 32'd0; end
    @(negedge clk);
    rst = 1'b0;
    txn(0, 1'b0, 32'h04, 32'd0, 4'd0, 0);
    check("abort_store_dropped", b0.rsp_rdata, 32'd0);
    txn(1, 1'b0, 32'h10, 32'd0, 4'd0, 0);
    check("reset_clears_l1", b1.rsp_rdata, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
